scmp_bus_ctl: RTL and testbench

External bus cycle sequencer for the SC/MP core. Executes one read or write memory cycle per request from the microcode sequencer. Handles multiprocessor bus arbitration through the BREQ/ENIN/ENOUT daisy chain and stretches the data strobe while HOLD_n is low. Sits between the microcode/register datapath and the chip pins, and owns ADS_n, RD_n, WR_n, addr and the D pin driver.

---
 rtl/scmp_bus_ctl.sv | 185 ++++++++++++++++++
 tb/tb_scmp_bus_ctl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/scmp_bus_ctl.sv
`default_nettype none
// ============================================================================
// Module   : scmp_bus_ctl
// Brief    : SC/MP external bus cycle sequencer with BREQ/ENIN/ENOUT arbitration
// Revision : 1.0 - initial release
// ============================================================================
module scmp_bus_ctl #(
  parameter int ADS_CYCLES = 1,
  parameter int STROBE_MIN = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cyc_req,
  input  logic        cyc_wr,
  input  logic [15:0] cyc_addr,
  input  logic [3:0]  cyc_flags,
  input  logic [7:0]  cyc_wdata,
  output logic        cyc_done,
  output logic [7:0]  cyc_rdata,
  output logic        breq_o,
  input  logic        enin,
  output logic        enout,
  input  logic        hold_n,
  output logic [11:0] addr,
  input  logic [7:0]  D_i,
  output logic [7:0]  D_o,
  output logic        D_oe,
  output logic        ADS_n,
  output logic        RD_n,
  output logic        WR_n
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARB  = 3'd1,
    ST_ADDR = 3'd2,
    ST_STRB = 3'd3,
    ST_END  = 3'd4
  } state_t;

  localparam logic [3:0] ADS_LAST = 4'(ADS_CYCLES - 1);
  localparam logic [3:0] STB_LAST = 4'(STROBE_MIN - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [15:0] lat_addr_q, lat_addr_d;
  logic [3:0]  flags_q, flags_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        ads_n_q, ads_n_d;
  logic        rd_n_q, rd_n_d;
  logic        wr_n_q, wr_n_d;
  logic        breq_q, breq_d;
  logic        d_oe_q, d_oe_d;
  logic        done_q, done_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [11:0] addr_q, addr_d;
  logic [7:0]  d_o_q, d_o_d;

  // Pin outputs are computed for the state being entered, so every pin is a flop.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    lat_addr_d = lat_addr_q;
    flags_d    = flags_q;
    wdata_d    = wdata_q;
    ads_n_d    = 1'b1;
    rd_n_d     = 1'b1;
    wr_n_d     = 1'b1;
    breq_d     = breq_q;
    d_oe_d     = d_oe_q;
    done_d     = 1'b0;
    rdata_d    = rdata_q;
    addr_d     = addr_q;
    d_o_d      = d_o_q;
    case (state_q)
      ST_IDLE: begin
        if (cyc_req) begin
          wr_d       = cyc_wr;
          lat_addr_d = cyc_addr;
          flags_d    = cyc_flags;
          wdata_d    = cyc_wdata;
          breq_d     = 1'b1;
          state_d    = ST_ARB;
        end
      end
      ST_ARB: begin
        if (enin) begin
          state_d = ST_ADDR;
          cnt_d   = '0;
          ads_n_d = 1'b0;
          addr_d  = lat_addr_q[11:0];
          d_o_d   = {flags_q, lat_addr_q[15:12]};
          d_oe_d  = 1'b1;
        end
      end
      ST_ADDR: begin
        if (cnt_q == ADS_LAST) begin
          state_d = ST_STRB;
          cnt_d   = '0;
          rd_n_d  = wr_q;
          wr_n_d  = ~wr_q;
          d_oe_d  = wr_q;
          if (wr_q) d_o_d = wdata_q;
        end else begin
          cnt_d   = cnt_q + 4'd1;
          ads_n_d = 1'b0;
        end
      end
      ST_STRB: begin
        // The counter saturates at the minimum; hold_n only stretches beyond it.
        if (cnt_q == STB_LAST && hold_n) begin
          state_d = ST_END;
          done_d  = 1'b1;
          breq_d  = 1'b0;
          if (!wr_q) rdata_d = D_i;
        end else begin
          if (cnt_q != STB_LAST) cnt_d = cnt_q + 4'd1;
          rd_n_d = wr_q;
          wr_n_d = ~wr_q;
        end
      end
      ST_END: begin
        state_d = ST_IDLE;
        d_oe_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        d_oe_d  = 1'b0;
        breq_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      lat_addr_q <= '0;
      flags_q    <= '0;
      wdata_q    <= '0;
      ads_n_q    <= 1'b1;
      rd_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      breq_q     <= 1'b0;
      d_oe_q     <= 1'b0;
      done_q     <= 1'b0;
      rdata_q    <= '0;
      addr_q     <= '0;
      d_o_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      lat_addr_q <= lat_addr_d;
      flags_q    <= flags_d;
      wdata_q    <= wdata_d;
      ads_n_q    <= ads_n_d;
      rd_n_q     <= rd_n_d;
      wr_n_q     <= wr_n_d;
      breq_q     <= breq_d;
      d_oe_q     <= d_oe_d;
      done_q     <= done_d;
      rdata_q    <= rdata_d;
      addr_q     <= addr_d;
      d_o_q      <= d_o_d;
    end
  end

  // The grant only passes through a device that is idle and not about to request.
  assign enout     = enin & (state_q == ST_IDLE) & ~cyc_req;
  assign cyc_done  = done_q;
  assign cyc_rdata = rdata_q;
  assign breq_o    = breq_q;
  assign addr      = addr_q;
  assign D_o       = d_o_q;
  assign D_oe      = d_oe_q;
  assign ADS_n     = ads_n_q;
  assign RD_n      = rd_n_q;
  assign WR_n      = wr_n_q;

endmodule
`default_nettype wire

// File: tb/tb_scmp_bus_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_scmp_bus_ctl
// Brief    : Scoreboard bench for scmp_bus_ctl, default and stretched timings
// Revision : 1.0 - initial release
// ============================================================================
module tb_scmp_bus_ctl;

  int n_chk  = 0;
  int n_pass = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [3:0]  flags;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    int          done_cyc;
    int          w;
    int          len;
  } exp_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  for (genvar G = 0; G < 2; G++) begin : g_cfg
    localparam int ADS  = (G == 0) ? 1 : 3;
    localparam int SMIN = (G == 0) ? 2 : 4;

    logic        rst_n     = 1'b0;
    logic        cyc_req   = 1'b0;
    logic        cyc_wr    = 1'b0;
    logic [15:0] cyc_addr  = '0;
    logic [3:0]  cyc_flags = '0;
    logic [7:0]  cyc_wdata = '0;
    logic        enin      = 1'b1;
    logic        hold_n    = 1'b1;
    logic [7:0]  d_i       = '0;
    logic        cyc_done, breq_o, enout, d_oe, ads_n, rd_n, wr_n;
    logic [7:0]  cyc_rdata, d_o;
    logic [11:0] addr;

    int         cycnt = 0;
    bit         fin   = 1'b0;
    exp_t       q[$];
    logic [7:0] model_rdata = '0;

    always @(posedge clk) cycnt <= cycnt + 1;

    scmp_bus_ctl #(.ADS_CYCLES(ADS), .STROBE_MIN(SMIN)) u_dut (
      .clk(clk), .rst_n(rst_n), .cyc_req(cyc_req), .cyc_wr(cyc_wr),
      .cyc_addr(cyc_addr), .cyc_flags(cyc_flags), .cyc_wdata(cyc_wdata),
      .cyc_done(cyc_done), .cyc_rdata(cyc_rdata), .breq_o(breq_o),
      .enin(enin), .enout(enout), .hold_n(hold_n), .addr(addr),
      .D_i(d_i), .D_o(d_o), .D_oe(d_oe), .ADS_n(ads_n), .RD_n(rd_n), .WR_n(wr_n)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      check($sformatf("cfg%0d %s", G, nm), act, exp);
    endtask

    task automatic apply_reset();
      #2 rst_n = 1'b0;
      #1 chk("async reset pins", 32'({ads_n, rd_n, wr_n, breq_o, d_oe, cyc_done}), 32'b111000);
      q.delete();
      model_rdata = '0;
      cyc_req = 1'b0;
      hold_n  = 1'b1;
      enin    = 1'b1;
      @(negedge clk);
      #2 rst_n = 1'b1;
    endtask

    task automatic idle_gap(input int n);
      for (int i = 0; i < n; i++) begin
        @(negedge clk);
        enin   = 1'($urandom);
        hold_n = 1'($urandom);
        #1 chk("enout follows enin when idle", 32'(enout), 32'(enin));
      end
    endtask

    // w: ARB cycles with enin low; h: strobe cycles with hold_n low from STRB entry.
    task automatic run_txn(input logic wr, input logic [15:0] a, input logic [3:0] fl,
                           input logic [7:0] wd, input logic [7:0] di, input int w,
                           input int h, input bit rst_mid);
      exp_t e;
      int   len;
      int   sidx;
      bit   ended;
      @(negedge clk);
      len        = (h + 1 > SMIN) ? h + 1 : SMIN;
      e.wr       = wr;
      e.addr     = a;
      e.flags    = fl;
      e.wdata    = wd;
      e.rdata    = wr ? model_rdata : di;
      e.done_cyc = cycnt + 1 + w + 1 + ADS + len;
      e.w        = w;
      e.len      = len;
      if (!wr && !rst_mid) model_rdata = di;
      q.push_back(e);
      cyc_req   = 1'b1;
      cyc_wr    = wr;
      cyc_addr  = a;
      cyc_flags = fl;
      cyc_wdata = wd;
      enin      = (w == 0);
      d_i       = 8'($urandom);
      if (w == 0) #1 chk("enout blocked by own request", 32'(enout), 32'd0);
      sidx  = 0;
      ended = 1'b0;
      for (int t = 1; t <= 400 && !ended; t++) begin
        @(negedge clk);
        if (t == 1) begin
          cyc_wr    = ~wr;
          cyc_addr  = 16'($urandom);
          cyc_flags = 4'($urandom);
          cyc_wdata = 8'($urandom);
        end
        if (t == w + 1) enin = 1'b1;
        else if (t > w + 1) enin = 1'($urandom);
        if (!rd_n || !wr_n) begin
          sidx++;
          if (rst_mid) begin
            apply_reset();
            ended = 1'b1;
          end else begin
            hold_n = (sidx <= h) ? 1'b0 : 1'b1;
            d_i    = (sidx == len) ? di : 8'($urandom);
          end
        end else begin
          hold_n = 1'($urandom);
          d_i    = 8'($urandom);
        end
        if (!ended && cyc_done) begin
          cyc_req = 1'b0;
          ended   = 1'b1;
        end
      end
      if (!ended) begin
        chk("cycle completion within budget", 32'(ended), 32'd1);
        apply_reset();
      end
    endtask

    initial begin : p_monitor
      int   nads  = 0;
      int   nstb  = 0;
      int   nbreq = 0;
      exp_t e;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          nads = 0; nstb = 0; nbreq = 0;
        end else if (q.size() == 0) begin
          chk("bus quiet without request", 32'({breq_o, ads_n, rd_n, wr_n, cyc_done}), 32'b01110);
        end else begin
          e = q[0];
          if (breq_o) begin
            nbreq++;
            chk("enout low while bus held", 32'(enout), 32'd0);
          end
          if (!ads_n) begin
            nads++;
            chk("ADS addr", 32'(addr), 32'(e.addr[11:0]));
            chk("ADS D_o", 32'(d_o), 32'({e.flags, e.addr[15:12]}));
            chk("ADS D_oe/strobes/breq", 32'({d_oe, rd_n, wr_n, breq_o}), 32'b1111);
          end
          if (!rd_n || !wr_n) begin
            nstb++;
            chk("strobe kind", 32'({ads_n, rd_n, wr_n}), 32'({1'b1, e.wr, ~e.wr}));
            chk("strobe addr", 32'(addr), 32'(e.addr[11:0]));
            chk("strobe D_oe", 32'(d_oe), 32'(e.wr));
            if (e.wr) chk("write D_o", 32'(d_o), 32'(e.wdata));
          end
          if (cyc_done) begin
            void'(q.pop_front());
            chk("done cycle", 32'(cycnt), 32'(e.done_cyc));
            chk("ADS length", 32'(nads), 32'(ADS));
            chk("strobe length", 32'(nstb), 32'(e.len));
            chk("breq length", 32'(nbreq), 32'(e.w + 1 + ADS + e.len));
            chk("cyc_rdata", 32'(cyc_rdata), 32'(e.rdata));
            chk("END pins", 32'({breq_o, ads_n, rd_n, wr_n, d_oe}), 32'({4'b0111, e.wr}));
            chk("END addr", 32'(addr), 32'(e.addr[11:0]));
            if (e.wr) chk("END D_o", 32'(d_o), 32'(e.wdata));
            nads = 0; nstb = 0; nbreq = 0;
          end
        end
      end
    end

    initial begin : p_driver
      repeat (2) @(negedge clk);
      chk("reset strobes", 32'({ads_n, rd_n, wr_n, breq_o, d_oe, cyc_done}), 32'b111000);
      chk("reset data", 32'({cyc_rdata, addr, d_o}), 32'd0);
      rst_n = 1'b1;
      idle_gap(3);
      run_txn(1'b0, 16'hA123, 4'h8, 8'h00, 8'h5A, 0, 0, 1'b0);
      run_txn(1'b1, 16'h0F0F, 4'h3, 8'hC3, 8'h00, 0, 0, 1'b0);
      run_txn(1'b0, 16'h1234, 4'h1, 8'h00, 8'h77, 6, 0, 1'b0);
      idle_gap(4);
      run_txn(1'b0, 16'hBEEF, 4'h4, 8'h00, 8'h96, 0, 3, 1'b0);
      run_txn(1'b0, 16'h4321, 4'h2, 8'h00, 8'h11, 0, 0, 1'b1);
      run_txn(1'b1, 16'h5555, 4'hF, 8'h3C, 8'h00, 0, 0, 1'b0);
      run_txn(1'b0, 16'h8001, 4'h6, 8'h00, 8'hE7, 0, 0, 1'b0);
      run_txn(1'b0, 16'h7FFE, 4'h9, 8'h00, 8'h42, 0, 0, 1'b0);
      for (int i = 0; i < 40; i++) begin
        run_txn(1'($urandom), 16'($urandom), 4'($urandom), 8'($urandom), 8'($urandom),
                int'($urandom_range(0, 3)),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0, 1'b0);
        if ($urandom_range(0, 2) == 0) idle_gap(int'($urandom_range(1, 3)));
      end
      idle_gap(3);
      chk("scoreboard drained", 32'(q.size()), 32'd0);
      fin = 1'b1;
    end
  end

  initial begin : p_summary
    fork
      wait (g_cfg[0].fin && g_cfg[1].fin);
      #500000;
    join_any
    check("both configurations finished", 32'({g_cfg[0].fin, g_cfg[1].fin}), 32'b11);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
